// File: rtl/mcp3008_responder.sv
// MCP3008 emulator: SPI responder running in the system clock domain.
// The SPI pins are oversampled, the start/SGL/D2..D0 command is decoded, and a
// 10-bit result (single-ended or clamped differential) is shifted back as
// null bit, MSB-first B9..B0, then LSB-first B1..B9, then zeros.
module mcp3008_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [79:0] ch_data,
   input  logic        spi_dclk,
   input  logic        spi_cs_n,
   input  logic        spi_din,
   output logic        spi_dout,
   output logic        spi_dout_oe,
   output logic        conv_valid,
   output logic [2:0]  conv_chan,
   output logic        conv_diff,
   output logic [9:0]  conv_value,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE, WAIT_START, CMD, SAMPLE, MSB_OUT, LSB_OUT, ZERO_OUT
   } state_t;

   state_t state, state_nxt;

   // one lane per pin: {dclk, cs_n, din}
   logic [SYNC_STAGES-1:0][2:0] sync_pipe;
   logic dclk_s, cs_s, din_s, dclk_prev, rise, fall;

   logic [3:0] bit_cnt, cnt_nxt;
   logic [3:0] cmd, cmd_nxt;          // {SGL, D2, D1, D0}
   logic       dout_nxt, oe_nxt, valid_nxt, diff_nxt;
   logic [2:0] chan_nxt;
   logic [9:0] value_nxt;

   logic [7:0][9:0] ch;
   logic [2:0]      pos_idx, neg_idx;
   logic [10:0]     delta;
   logic [9:0]      sel_value;

   assign ch      = ch_data;
   assign dclk_s  = sync_pipe[SYNC_STAGES-1][2];
   assign cs_s    = sync_pipe[SYNC_STAGES-1][1];
   assign din_s   = sync_pipe[SYNC_STAGES-1][0];
   assign rise    = dclk_s & ~dclk_prev;
   assign fall    = ~dclk_s & dclk_prev;
   assign busy    = (state != IDLE);

   // synchronize the SPI pins and keep the previous dclk for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_pipe <= '0;
         dclk_prev <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], {spi_dclk, spi_cs_n, spi_din}};
         dclk_prev <= dclk_s;
      end
   end

   // channel selection; differential pairs swap on D0, so IN- is IN+ with D0 flipped
   always_comb begin
      pos_idx = cmd[2:0];
      neg_idx = {cmd[2:1], ~cmd[0]};
      delta   = {1'b0, ch[pos_idx]} - {1'b0, ch[neg_idx]};
      if (cmd[3])
         sel_value = ch[pos_idx];
      else if (delta[10])
         sel_value = 10'd0;
      else
         sel_value = delta[9:0];
   end

   // register all frame state; conv_* hold their values across aborts
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         cmd         <= '0;
         spi_dout    <= 1'b0;
         spi_dout_oe <= 1'b0;
         conv_valid  <= 1'b0;
         conv_chan   <= '0;
         conv_diff   <= 1'b0;
         conv_value  <= '0;
      end else begin
         state       <= state_nxt;
         bit_cnt     <= cnt_nxt;
         cmd         <= cmd_nxt;
         spi_dout    <= dout_nxt;
         spi_dout_oe <= oe_nxt;
         conv_valid  <= valid_nxt;
         conv_chan   <= chan_nxt;
         conv_diff   <= diff_nxt;
         conv_value  <= value_nxt;
      end
   end

   // next-state and output logic; a high cs_n pre-empts any dclk edge
   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_cnt;
      cmd_nxt   = cmd;
      dout_nxt  = spi_dout;
      oe_nxt    = spi_dout_oe;
      valid_nxt = 1'b0;
      chan_nxt  = conv_chan;
      diff_nxt  = conv_diff;
      value_nxt = conv_value;
      if (state != IDLE && cs_s) begin
         state_nxt = WAIT_START;
         cnt_nxt   = '0;
         dout_nxt  = 1'b0;
         oe_nxt    = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // a frame already running at reset is skipped until cs_n goes high
               if (cs_s) state_nxt = WAIT_START;
            end
            WAIT_START: begin
               if (rise && din_s) begin
                  state_nxt = CMD;
                  cnt_nxt   = '0;
               end
            end
            CMD: begin
               if (rise) begin
                  cmd_nxt = {cmd[2:0], din_s};
                  if (bit_cnt == 4'd3) begin
                     state_nxt = SAMPLE;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = bit_cnt + 4'd1;
                  end
               end
            end
            SAMPLE: begin
               // first fall closes the D0 clock; the second ends sampling
               if (fall) begin
                  if (bit_cnt == 4'd0) begin
                     cnt_nxt = 4'd1;
                  end else begin
                     dout_nxt  = 1'b0;
                     oe_nxt    = 1'b1;
                     valid_nxt = 1'b1;
                     value_nxt = sel_value;
                     chan_nxt  = cmd[2:0];
                     diff_nxt  = ~cmd[3];
                     state_nxt = MSB_OUT;
                     cnt_nxt   = '0;
                  end
               end
            end
            MSB_OUT: begin
               if (fall) begin
                  dout_nxt = conv_value[4'd9 - bit_cnt];
                  if (bit_cnt == 4'd9) begin
                     state_nxt = LSB_OUT;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = bit_cnt + 4'd1;
                  end
               end
            end
            LSB_OUT: begin
               // B0 was the last MSB-first bit, so LSB-first restarts at B1
               if (fall) begin
                  dout_nxt = conv_value[bit_cnt + 4'd1];
                  if (bit_cnt == 4'd8) begin
                     state_nxt = ZERO_OUT;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = bit_cnt + 4'd1;
                  end
               end
            end
            ZERO_OUT: begin
               if (fall) dout_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed bench for mcp3008_responder: SPI frames in mode 0,0 and 1,1,
// differential clamping, aborts, mid-frame reset and dout update latency.
module tb_mcp3008_responder;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [79:0] ch_data;
   logic        spi_dclk, spi_cs_n, spi_din;
   logic        spi_dout, spi_dout_oe, conv_valid, conv_diff, busy;
   logic [2:0]  conv_chan;
   logic [9:0]  conv_value;

   int n_total = 0;
   int n_pass  = 0;
   int vcnt    = 0;
   logic [2:0] lchan = '0;
   logic       ldiff = 1'b0;
   logic [9:0] lval  = '0;

   mcp3008_responder #(.SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .ch_data(ch_data),
      .spi_dclk(spi_dclk), .spi_cs_n(spi_cs_n), .spi_din(spi_din),
      .spi_dout(spi_dout), .spi_dout_oe(spi_dout_oe), .conv_valid(conv_valid),
      .conv_chan(conv_chan), .conv_diff(conv_diff), .conv_value(conv_value),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // record every conv_valid pulse
   always @(posedge clk) begin
      if (conv_valid === 1'b1) begin
         vcnt  <= vcnt + 1;
         lchan <= conv_chan;
         ldiff <= conv_diff;
         lval  <= conv_value;
      end
   end

   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // frame bits in send order (first sent = MSB): null, B9..B0, B1..B9, two zeros
   function automatic logic [21:0] exp_rx(input logic [9:0] v);
      logic [8:0] r;
      for (int i = 0; i < 9; i++) r[8-i] = v[i+1];
      return {1'b0, v, r, 2'b00};
   endfunction

   // one dclk period: fall, low half (din set), sample dout, rise, high half
   task automatic cycle(input logic b, input bit timed, input logic pv, input logic nv,
                        output logic s, output logic o);
      spi_dclk = 1'b0;
      spi_din  = b;
      if (timed) begin
         tick(S);
         chk("lat_hold", spi_dout, pv);
         tick(1);
         chk("lat_update", spi_dout, nv);
         tick(4 - S - 1);
      end else begin
         tick(4);
      end
      s = spi_dout;
      o = spi_dout_oe;
      spi_dclk = 1'b1;
      tick(4);
   endtask

   // nz leading zeros, start bit, cmd {SGL,D2,D1,D0}, then zeros; ncyc periods total
   task automatic frame(input bit m11, input int nz, input logic [3:0] cmd, input int ncyc,
                        output logic [21:0] rx, output bit oe_ok);
      logic s, o, b;
      rx = '0;
      oe_ok = 1'b1;
      spi_dclk = m11;
      spi_cs_n = 1'b0;
      tick(4);
      for (int k = 0; k < ncyc; k++) begin
         if (k < nz) b = 1'b0;
         else if (k == nz) b = 1'b1;
         else if (k <= nz + 4) b = cmd[nz + 4 - k];
         else b = 1'b0;
         cycle(b, 1'b0, 1'b0, 1'b0, s, o);
         if (k >= nz + 6 && k <= nz + 27) begin
            rx = {rx[20:0], s};
            if (k <= nz + 25 && o !== 1'b1) oe_ok = 1'b0;
         end else if (k < nz + 6 && o !== 1'b0) begin
            oe_ok = 1'b0;
         end
      end
   endtask

   task automatic cs_up(input bit m11);
      spi_cs_n = 1'b1;
      tick(S + 2);
      chk("csup_oe", spi_dout_oe, 1'b0);
      chk("csup_dout", spi_dout, 1'b0);
      spi_dclk = m11;
      tick(4);
   endtask

   task automatic check_conv(input string tag, input int v0, input logic [2:0] c,
                             input logic d, input logic [9:0] v);
      chk({tag, "_pulses"}, vcnt - v0, 1);
      chk({tag, "_chan"}, lchan, c);
      chk({tag, "_diff"}, ldiff, d);
      chk({tag, "_value"}, lval, v);
      chk({tag, "_hold"}, conv_value, v);
   endtask

   initial begin
      logic [21:0] rx;
      logic [21:0] e;
      bit          ok;
      int          v0;
      logic        s, o, pv, nv;

      rst = 1'b1; ch_data = '0; spi_dclk = 1'b0; spi_cs_n = 1'b1; spi_din = 1'b0;
      tick(3);
      chk("rst_dout", spi_dout, 0);
      chk("rst_oe", spi_dout_oe, 0);
      chk("rst_valid", conv_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_value", conv_value, 0);
      chk("rst_chan", {conv_diff, conv_chan}, 0);
      rst = 1'b0;
      tick(S + 2);
      chk("wait_start_busy", busy, 1);

      // single-ended CH3 in mode 0,0
      ch_data[30 +: 10] = 10'h2A5;
      v0 = vcnt;
      frame(1'b0, 0, 4'b1011, 28, rx, ok);
      chk("se_bits", rx, 22'b0_1010100101_010010101_00);
      chk("se_oe", ok, 1);
      check_conv("se", v0, 3'd3, 1'b0, 10'h2A5);
      cs_up(1'b0);

      // differential pair 0/1
      ch_data[0 +: 10] = 10'h300;
      ch_data[10 +: 10] = 10'h100;
      v0 = vcnt;
      frame(1'b0, 0, 4'b0000, 28, rx, ok);
      chk("diff_pos_bits", rx, exp_rx(10'h200));
      chk("diff_pos_oe", ok, 1);
      check_conv("diff_pos", v0, 3'd0, 1'b1, 10'h200);
      cs_up(1'b0);
      v0 = vcnt;
      frame(1'b0, 0, 4'b0001, 28, rx, ok);
      chk("diff_clamp_bits", rx, 22'd0);
      check_conv("diff_clamp", v0, 3'd1, 1'b1, 10'h000);
      cs_up(1'b0);
      ch_data[0 +: 10] = 10'h3FF;
      ch_data[10 +: 10] = 10'h000;
      v0 = vcnt;
      frame(1'b0, 0, 4'b0000, 28, rx, ok);
      chk("diff_full_bits", rx, exp_rx(10'h3FF));
      check_conv("diff_full", v0, 3'd0, 1'b1, 10'h3FF);
      cs_up(1'b0);

      // mode 1,1 with three leading zeros
      v0 = vcnt;
      frame(1'b1, 3, 4'b1011, 31, rx, ok);
      chk("m11_bits", rx, 22'b0_1010100101_010010101_00);
      chk("m11_oe", ok, 1);
      check_conv("m11", v0, 3'd3, 1'b0, 10'h2A5);
      cs_up(1'b1);

      // abort during the command, then a full CH7 frame
      ch_data[70 +: 10] = 10'h155;
      v0 = vcnt;
      frame(1'b0, 0, 4'b1111, 4, rx, ok);
      cs_up(1'b0);
      chk("abort_cmd_no_valid", vcnt - v0, 0);
      frame(1'b0, 0, 4'b1111, 28, rx, ok);
      chk("after_abort_bits", rx, exp_rx(10'h155));
      check_conv("after_abort", v0, 3'd7, 1'b0, 10'h155);
      cs_up(1'b0);

      // abort while shifting out; conv outputs keep the last value
      v0 = vcnt;
      frame(1'b0, 0, 4'b1011, 12, rx, ok);
      chk("abort_out_oe_before", spi_dout_oe, 1);
      cs_up(1'b0);
      chk("abort_out_hold", conv_value, 10'h2A5);
      chk("abort_out_pulses", vcnt - v0, 1);

      // reset inside MSB_OUT with cs_n held low
      frame(1'b0, 0, 4'b1011, 10, rx, ok);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("midrst_dout", spi_dout, 0);
      chk("midrst_oe", spi_dout_oe, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_value", conv_value, 0);
      v0 = vcnt;
      for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0, s, o);
      chk("midrst_ignored_oe", spi_dout_oe, 0);
      chk("midrst_ignored_busy", busy, 0);
      chk("midrst_ignored_valid", vcnt - v0, 0);
      cs_up(1'b0);
      chk("midrst_release_busy", busy, 1);
      v0 = vcnt;
      frame(1'b0, 0, 4'b1111, 28, rx, ok);
      chk("midrst_next_bits", rx, exp_rx(10'h155));
      check_conv("midrst_next", v0, 3'd7, 1'b0, 10'h155);
      cs_up(1'b0);

      // exact dout latency after each falling pin edge; CH3 changes mid-frame
      e = 22'b0_1010100101_010010101_00;
      v0 = vcnt;
      spi_dclk = 1'b0;
      spi_cs_n = 1'b0;
      tick(4);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, s, o);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, s, o);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, s, o);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, s, o);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, s, o);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, s, o);
      for (int k = 6; k < 28; k++) begin
         pv = (k == 6) ? 1'b0 : e[21 - (k - 7)];
         nv = e[21 - (k - 6)];
         cycle(1'b0, 1'b1, pv, nv, s, o);
         chk("lat_stable", s, nv);
         if (k == 7) ch_data[30 +: 10] = 10'h000;
      end
      check_conv("lat", v0, 3'd3, 1'b0, 10'h2A5);
      cs_up(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
